hex_keypad_scanner: RTL

Scans a 4x4 hex keypad on the FPGA board, debounces it, and reports each new keypress as a 4-bit hex digit. This is the input-side counterpart of the 7-segment digit encoder. The encoder turns a 4-bit digit into enable-LOW segment drives. This block turns enable-LOW keypad lines back into a 4-bit digit, and that digit feeds the CPU I/O path or the display.

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/sync_2ff.sv | 23 ++
 rtl/hex_keypad_scanner.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key map and row decode helper for the hex keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED
  } scan_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] row;
  } row_dec_t;

  // Indexed by {row, col}; rows and columns numbered from the active-low bit position.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic row_dec_t decode_row(input logic [3:0] rows);
    row_dec_t d;
    d.valid = 1'b1;
    d.row   = 2'd0;
    case (rows)
      4'b1110: d.row = 2'd0;
      4'b1101: d.row = 2'd1;
      4'b1011: d.row = 2'd2;
      4'b0111: d.row = 2'd3;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones (idle pull-up level).
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hex_keypad_scanner.sv
// Scans a 4x4 active-low keypad, debounces press and release on divider ticks,
// and reports each accepted key as a hex digit with a one-cycle valid pulse.
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_drive,
  input  logic [3:0] row_sense,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

  logic [3:0]       rows_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  scan_state_t      state, state_n;
  logic [1:0]       col_idx, col_n;
  logic [3:0]       latched, latched_n;
  logic [CNT_W-1:0] match_cnt, match_n;
  logic [CNT_W-1:0] rel_cnt, rel_n;
  logic [3:0]       key_code_n;
  logic             key_valid_n;
  logic             judge;
  logic [3:0]       judge_pat;
  row_dec_t         dec;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_sense),
    .q   (rows_s)
  );

  // Free-running divider so tick phase never depends on FSM activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

  always_comb begin
    state_n     = state;
    col_n       = col_idx;
    latched_n   = latched;
    match_n     = match_cnt;
    rel_n       = rel_cnt;
    key_code_n  = key_code;
    key_valid_n = 1'b0;
    judge       = 1'b0;
    judge_pat   = latched;
    dec         = '0;

    case (state)
      SCAN: begin
        if (tick) begin
          if (rows_s == 4'hF) begin
            col_n = col_idx + 2'd1;
          end else begin
            latched_n = rows_s;
            match_n   = CNT_W'(1);
            if (DEBOUNCE_CNT == 1) begin
              judge     = 1'b1;
              judge_pat = rows_s;
            end else begin
              state_n = DEBOUNCE;
            end
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (rows_s == latched) begin
            if (int'(match_cnt) + 1 >= DEBOUNCE_CNT) begin
              judge     = 1'b1;
              judge_pat = latched;
            end else begin
              match_n = match_cnt + CNT_W'(1);
            end
          end else begin
            state_n = SCAN;
            col_n   = col_idx + 2'd1;
          end
        end
      end

      PRESSED: begin
        if (tick) begin
          if (rows_s == 4'hF) begin
            if (int'(rel_cnt) + 1 >= DEBOUNCE_CNT) begin
              state_n = SCAN;
              col_n   = col_idx + 2'd1;
              rel_n   = '0;
            end else begin
              rel_n = rel_cnt + CNT_W'(1);
            end
          end else begin
            rel_n = '0;
          end
        end
      end

      default: begin
        state_n = SCAN;
      end
    endcase

    // A stable pattern is accepted only when exactly one row is low.
    if (judge) begin
      dec = decode_row(judge_pat);
      if (dec.valid) begin
        state_n     = PRESSED;
        key_code_n  = KEY_MAP[{dec.row, col_idx}];
        key_valid_n = 1'b1;
        rel_n       = '0;
      end else begin
        state_n = SCAN;
        col_n   = col_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      col_drive <= 4'b1110;
      latched   <= 4'hF;
      match_cnt <= '0;
      rel_cnt   <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      col_idx   <= col_n;
      col_drive <= ~(4'b0001 << col_n);
      latched   <= latched_n;
      match_cnt <= match_n;
      rel_cnt   <= rel_n;
      key_code  <= key_code_n;
      key_valid <= key_valid_n;
      key_held  <= (state_n == PRESSED);
    end
  end

endmodule
